// File: rtl/ckt_sweep_pkg.sv
// Shared types and defaults for the truth-table sweep controller and its
// helpers.
package ckt_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } sweep_state_e;

    localparam int DEF_N_IN   = 3;
    localparam int DEF_N_OUT  = 2;
    localparam int DEF_SETTLE = 1;

    function automatic int vec_count(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/ckt_sweep_ctrl_settle_timer.sv
// Loadable down-counter with a zero flag; holds each stimulus vector for a
// fixed number of cycles before the outputs are compared.
module settle_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/ckt_sweep_ctrl.sv
// Exhaustive truth-table sequencer: drives every input combination onto a
// combinational circuit and checks its outputs against a supplied table.
module ckt_sweep_ctrl
    import ckt_sweep_pkg::*;
#(
    parameter int N_IN   = DEF_N_IN,
    parameter int N_OUT  = DEF_N_OUT,
    parameter int SETTLE = DEF_SETTLE
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             abort,
    input  logic [N_OUT*vec_count(N_IN)-1:0] exp_table,
    input  logic [N_OUT-1:0]                 dut_out,
    output logic [N_IN-1:0]                  dut_in,
    output logic                             busy,
    output logic                             done,
    output logic                             pass,
    output logic [N_IN:0]                    err_count,
    output logic [N_IN-1:0]                  first_err_idx,
    output logic                             first_err_vld,
    output logic [N_OUT-1:0]                 err_mask
);

    localparam int VEC = vec_count(N_IN);
    localparam int TW  = $clog2(SETTLE) + 1;

    sweep_state_e     state_q, state_d;
    logic [N_IN-1:0]  dut_in_q, dut_in_d;
    logic [N_IN:0]    err_count_q, err_count_d;
    logic [N_IN-1:0]  first_err_idx_q, first_err_idx_d;
    logic             first_err_vld_q, first_err_vld_d;
    logic [N_OUT-1:0] err_mask_q, err_mask_d;
    logic             pass_q, pass_d;

    logic             tmr_load;
    logic             tmr_dec;
    logic             tmr_zero;
    logic [N_OUT-1:0] exp_vec;
    logic [N_OUT-1:0] diff;

    settle_timer #(
        .W(TW)
    ) u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (TW'(SETTLE - 1)),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // Constant-index slice mux keeps the table lookup free of variable part-selects.
    always_comb begin
        exp_vec = '0;
        for (int i = 0; i < VEC; i++) begin
            if (dut_in_q == N_IN'(i)) begin
                exp_vec = exp_table[i*N_OUT +: N_OUT];
            end
        end
    end

    assign diff = dut_out ^ exp_vec;

    always_comb begin
        state_d         = state_q;
        dut_in_d        = dut_in_q;
        err_count_d     = err_count_q;
        first_err_idx_d = first_err_idx_q;
        first_err_vld_d = first_err_vld_q;
        err_mask_d      = err_mask_q;
        pass_d          = pass_q;
        tmr_load        = 1'b0;
        tmr_dec         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    err_count_d     = '0;
                    err_mask_d      = '0;
                    first_err_vld_d = 1'b0;
                    pass_d          = 1'b0;
                    dut_in_d        = '0;
                    tmr_load        = 1'b1;
                    state_d         = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    dut_in_d = '0;
                    pass_d   = 1'b0;
                    state_d  = ST_IDLE;
                end else if (tmr_zero) begin
                    state_d = ST_CHECK;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_CHECK: begin
                if (abort) begin
                    dut_in_d = '0;
                    pass_d   = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    if (diff != '0) begin
                        err_count_d = err_count_q + (N_IN+1)'(1);
                        err_mask_d  = err_mask_q | diff;
                        if (!first_err_vld_q) begin
                            first_err_idx_d = dut_in_q;
                            first_err_vld_d = 1'b1;
                        end
                    end
                    // The final vector's result must be folded into pass.
                    if (&dut_in_q) begin
                        pass_d  = (err_count_d == '0);
                        state_d = ST_DONE;
                    end else begin
                        dut_in_d = dut_in_q + N_IN'(1);
                        tmr_load = 1'b1;
                        state_d  = ST_SETTLE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            dut_in_q        <= '0;
            err_count_q     <= '0;
            first_err_idx_q <= '0;
            first_err_vld_q <= 1'b0;
            err_mask_q      <= '0;
            pass_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            dut_in_q        <= dut_in_d;
            err_count_q     <= err_count_d;
            first_err_idx_q <= first_err_idx_d;
            first_err_vld_q <= first_err_vld_d;
            err_mask_q      <= err_mask_d;
            pass_q          <= pass_d;
        end
    end

    assign dut_in        = dut_in_q;
    assign busy          = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
    assign done          = (state_q == ST_DONE);
    assign pass          = pass_q;
    assign err_count     = err_count_q;
    assign first_err_idx = first_err_idx_q;
    assign first_err_vld = first_err_vld_q;
    assign err_mask      = err_mask_q;

endmodule

// File: doc/ckt_sweep_ctrl.md
Name: ckt_sweep_ctrl

Overview:
Exhaustive truth-table sequencer for the small combinational lab circuits (three inputs, two outputs by default). On a start request it drives every input combination 0..2^N_IN-1 onto the circuit under test and waits a settle time. It then compares the circuit's outputs against an expected table supplied on a port, and reports pass/fail, error count, first failing index and a per-output mismatch mask. It sits beside the combinational unit as its self-check controller, replacing hand-written stimulus sequences.

Parameters:
N_IN, 3, number of circuit inputs; sweep length is 2^N_IN vectors
N_OUT, 2, number of circuit outputs
SETTLE, 1, cycles each vector is held before comparison; legal range >= 1

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  sweep request; sampled only in IDLE
abort  input  1  synchronous abort of a running sweep
exp_table  input  N_OUT*2^N_IN  expected outputs; slice [i*N_OUT +: N_OUT] is the expected dut_out for index i
dut_out  input  N_OUT  outputs of the circuit under test (e.g. {F1,F2}, F1 = MSB)
dut_in  output  N_IN  vector driven to the circuit (e.g. {x,y,z}, x = MSB), registered
busy  output  1  high while a sweep is running (SETTLE or CHECK)
done  output  1  one-cycle pulse when a sweep completes normally
pass  output  1  1 when the last completed sweep had zero mismatches
err_count  output  N_IN+1  number of mismatching vectors in the current or last sweep
first_err_idx  output  N_IN  index of the first mismatching vector
first_err_vld  output  1  first_err_idx is valid
err_mask  output  N_OUT  OR of (dut_out XOR expected) across all checked vectors

Behaviour:
- Reset: clk rising edge with rst_n=0 forces state IDLE and all outputs to 0, including dut_in and the result registers. Reset mid-sweep behaves the same and no done pulse is produced.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE: when start=1, clears err_count, err_mask, first_err_vld and pass, sets idx=0 and dut_in=0, loads the settle counter with SETTLE-1, then goes to SETTLE. When start=0, all result registers hold.
- SETTLE: lasts exactly SETTLE cycles; counter decrements; goes to CHECK when the counter is 0.
- CHECK: one cycle. Compares dut_out with exp_table[idx*N_OUT +: N_OUT].
  - On mismatch: err_count++, err_mask |= difference. If first_err_vld=0, latches first_err_idx=idx and sets first_err_vld=1.
  - If idx = 2^N_IN-1, goes to DONE.
  - Otherwise idx++, dut_in=idx+1, counter reloaded, goes to SETTLE.
- DONE: done=1 for one cycle; pass=(final err_count==0), including the last CHECK's result; returns to IDLE. dut_in holds the last vector until the next start.
- Latency: start sampled at edge 0 → done high during cycle 2^N_IN*(SETTLE+1)+1. With defaults that is cycle 17.
- busy=1 exactly in SETTLE and CHECK.
- start in SETTLE, CHECK or DONE is ignored and not queued.
- abort=1 in SETTLE or CHECK → IDLE on the next edge with dut_in=0. Results stay frozen at their partial values, pass=0, no done pulse. abort has priority over the CHECK transition but not over rst_n. abort in IDLE or DONE is ignored.
- err_count cannot overflow: its width covers 2^N_IN.
- exp_table and dut_out are sampled only in CHECK; changes at other times have no effect.

Decomposition:
- Package ckt_sweep_pkg holds:
  - the state enum (IDLE, SETTLE, CHECK, DONE);
  - default constants for N_IN, N_OUT and SETTLE;
  - a localparam function for the vector count 2^N_IN.
- One sub-module, settle_timer: a loadable down-counter with a zero flag, width $clog2(SETTLE)+1. It is reused by later lab controllers.
- The comparison and slice selection stay inline.

Test Plan:
1. Bench model F1=x&y, F2=x^z; correct exp_table; start pulse at cycle 0 → dut_in steps 0..7, each held 2 cycles; done during cycle 17; pass=1, err_count=0, first_err_vld=0, err_mask=00.
2. Same model, expected F1 bit at index 5 flipped → err_count=1, first_err_idx=5, first_err_vld=1, err_mask=10, pass=0.
3. exp_table bitwise inverted → err_count=8, first_err_idx=0, err_mask=11, pass=0.
4. SETTLE=3 build, correct table → each vector held 4 cycles, done during cycle 33, pass=1.
5. abort at cycle 6 with start held high throughout → busy=0 and dut_in=0 next cycle, done never pulses, pass=0. Because start is still high in IDLE, a new sweep begins one cycle later with counters cleared.
6. rst_n=0 for one edge at cycle 9 of a sweep with errors → all outputs 0 next cycle, state IDLE, no done. A fresh start then reproduces scenario 1 exactly.
